// File: rtl/spmv_pe_if.sv
// Private memory and scratchpad request/response ports of one SpMV processing element.
interface spmv_pe_if;
  localparam int unsigned ADDR_W  = 48;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned SADDR_W = 13;

  logic               req_mem_ld;
  logic               req_mem_st;
  logic [ADDR_W-1:0]  req_mem_addr;
  logic [DATA_W-1:0]  req_mem_d_or_tag;
  logic               req_mem_stall;
  logic               rsp_mem_push;
  logic [TAG_W-1:0]   rsp_mem_tag;
  logic [DATA_W-1:0]  rsp_mem_q;
  logic               rsp_mem_stall;
  logic               req_scratch_ld;
  logic               req_scratch_st;
  logic [SADDR_W-1:0] req_scratch_addr;
  logic [DATA_W-1:0]  req_scratch_d;
  logic               req_scratch_stall;
  logic               rsp_scratch_push;
  logic [DATA_W-1:0]  rsp_scratch_q;
  logic               rsp_scratch_stall;

  modport master (
    output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
    input  req_mem_stall,
    input  rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    output rsp_mem_stall,
    output req_scratch_ld, req_scratch_st, req_scratch_addr, req_scratch_d,
    input  req_scratch_stall,
    input  rsp_scratch_push, rsp_scratch_q,
    output rsp_scratch_stall
  );

  modport slave (
    input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
    output req_mem_stall,
    output rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    input  rsp_mem_stall,
    input  req_scratch_ld, req_scratch_st, req_scratch_addr, req_scratch_d,
    output req_scratch_stall,
    output rsp_scratch_push, rsp_scratch_q,
    input  rsp_scratch_stall
  );
endinterface

// File: rtl/spmv_pe.sv
// SpMV processing element: opcode decode, argument registers, decoder-table copy into
// scratchpad and the bring-up STEADY pass streaming x words into y through a response FIFO.
module spmv_pe #(
  parameter int unsigned ID          = 0,
  parameter int unsigned OUTSTANDING = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] op_in,
  output logic [63:0] op_out,
  input  logic        busy_in,
  output logic        busy_out,
  spmv_pe_if.master   bus
);
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ADDR_W  = 48;
  localparam int unsigned SADDR_W = 13;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned CNT_W   = 48;
  localparam int unsigned NREG    = 16;
  localparam int unsigned PTR_W   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned OCNT_W  = $clog2(OUTSTANDING + 1);

  localparam logic [5:0] OP_RST       = 6'd1;
  localparam logic [5:0] OP_LD        = 6'd2;
  localparam logic [5:0] OP_LD_DELTA  = 6'd3;
  localparam logic [5:0] OP_LD_PREFIX = 6'd4;
  localparam logic [5:0] OP_LD_COMMON = 6'd5;
  localparam logic [5:0] OP_STEADY    = 6'd6;

  typedef struct packed {
    logic [45:0] value;
    logic [3:0]  idx;
    logic [7:0]  pe;
    logic [5:0]  opc;
  } op_t;

  typedef enum logic [1:0] { S_IDLE, S_COPY, S_STEADY, S_DRAIN } state_e;

  state_e              state_q, state_d;
  logic                steady_mode_q, steady_mode_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [CNT_W-1:0]    ld_left_q, ld_left_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
  logic [ADDR_W-1:0]   st_addr_q, st_addr_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [OCNT_W-1:0]   outst_q, outst_d;
  logic [OCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                mem_ld_q, mem_ld_d;
  logic                mem_st_q, mem_st_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_d_q, mem_d_d;
  logic                sc_st_q, sc_st_d;
  logic [SADDR_W-1:0]  sc_addr_q, sc_addr_d;
  logic [DATA_W-1:0]   sc_d_q, sc_d_d;

  logic [DATA_W-1:0]   fifo_mem [OUTSTANDING];

  op_t                 op_c;
  logic                hit_c;
  logic                soft_rst_c;
  logic                push_c;
  logic                pop_c;
  logic                issue_c;
  logic                fifo_full_c;
  logic [OCNT_W:0]     inflight_c;
  logic [DATA_W-1:0]   fifo_head_c;
  logic [CNT_W-1:0]    copy_words_c;
  logic [CNT_W-1:0]    steady_words_c;
  logic                unused_c;

  assign op_c           = op_in;
  assign hit_c          = (op_c.pe == 8'(ID));
  assign soft_rst_c     = hit_c && (op_c.opc == OP_RST);
  assign fifo_full_c    = (fifo_cnt_q == OCNT_W'(OUTSTANDING));
  assign inflight_c     = (OCNT_W+1)'(outst_q) + (OCNT_W+1)'(fifo_cnt_q);
  assign fifo_head_c    = fifo_mem[rd_ptr_q];
  assign copy_words_c   = CNT_W'(regs_q[9] >> 3);
  assign steady_words_c = CNT_W'((regs_q[1] - regs_q[0] + 64'd7) >> 3);
  // Responses arriving with nothing outstanding belong to an aborted pass and are dropped.
  assign push_c         = bus.rsp_mem_push && (outst_q != '0) && !fifo_full_c;

  // Next-state, issue/retire and register-file logic
  always_comb begin
    state_d       = state_q;
    steady_mode_d = steady_mode_q;
    op_d          = op_in;
    regs_d        = regs_q;
    ld_left_d     = ld_left_q;
    ld_addr_d     = ld_addr_q;
    st_addr_d     = st_addr_q;
    tag_d         = tag_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_ld_d      = 1'b0;
    mem_st_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_d_d       = mem_d_q;
    sc_st_d       = 1'b0;
    sc_addr_d     = sc_addr_q;
    sc_d_d        = sc_d_q;
    pop_c         = 1'b0;
    issue_c       = 1'b0;

    // Retire the FIFO head; STEADY stores win the shared memory port over new loads
    if (state_q != S_IDLE && fifo_cnt_q != '0) begin
      if (steady_mode_q) begin
        if (!bus.req_mem_stall) begin
          pop_c      = 1'b1;
          mem_st_d   = 1'b1;
          mem_addr_d = {st_addr_q[ADDR_W-1:3], 3'b000};
          mem_d_d    = fifo_head_c;
          st_addr_d  = st_addr_q + ADDR_W'(8);
        end
      end else if (!bus.req_scratch_stall) begin
        pop_c     = 1'b1;
        sc_st_d   = 1'b1;
        sc_addr_d = st_addr_q[SADDR_W-1:0];
        sc_d_d    = fifo_head_c;
        st_addr_d = st_addr_q + ADDR_W'(1);
      end
    end

    if ((state_q == S_COPY || state_q == S_STEADY) && ld_left_q != '0 &&
        !bus.req_mem_stall && !(pop_c && steady_mode_q) &&
        inflight_c < (OCNT_W+1)'(OUTSTANDING)) begin
      issue_c    = 1'b1;
      mem_ld_d   = 1'b1;
      mem_addr_d = {ld_addr_q[ADDR_W-1:3], 3'b000};
      mem_d_d    = DATA_W'(tag_q);
      ld_addr_d  = ld_addr_q + ADDR_W'(8);
      tag_d      = tag_q + TAG_W'(1);
      ld_left_d  = ld_left_q - CNT_W'(1);
    end

    outst_d    = outst_q + OCNT_W'(issue_c) - OCNT_W'(push_c);
    fifo_cnt_d = fifo_cnt_q + OCNT_W'(push_c) - OCNT_W'(pop_c);
    if (push_c) wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (hit_c) begin
          unique case (op_c.opc)
            OP_LD: regs_d[op_c.idx] = DATA_W'(op_c.value);
            OP_LD_DELTA, OP_LD_PREFIX, OP_LD_COMMON: begin
              steady_mode_d = 1'b0;
              ld_left_d     = copy_words_c;
              ld_addr_d     = ADDR_W'(regs_q[4]);
              st_addr_d     = ADDR_W'(regs_q[5] >> 3);
              tag_d         = '0;
              state_d       = (copy_words_c == '0) ? S_DRAIN : S_COPY;
            end
            OP_STEADY: begin
              steady_mode_d = 1'b1;
              ld_addr_d     = ADDR_W'(regs_q[2]);
              st_addr_d     = ADDR_W'(regs_q[0]);
              tag_d         = '0;
              if (regs_q[0] < regs_q[1]) begin
                ld_left_d = steady_words_c;
                state_d   = S_STEADY;
              end else begin
                ld_left_d = '0;
                state_d   = S_DRAIN;
              end
            end
            default: ;
          endcase
        end
      end
      S_COPY, S_STEADY: if (ld_left_q == '0) state_d = S_DRAIN;
      S_DRAIN:          if (outst_q == '0 && fifo_cnt_q == '0) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase

    // Soft reset clears everything except the forwarded opcode
    if (soft_rst_c) begin
      state_d       = S_IDLE;
      steady_mode_d = 1'b0;
      regs_d        = '{default: '0};
      ld_left_d     = '0;
      ld_addr_d     = '0;
      st_addr_d     = '0;
      tag_d         = '0;
      outst_d       = '0;
      fifo_cnt_d    = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      mem_ld_d      = 1'b0;
      mem_st_d      = 1'b0;
      mem_addr_d    = '0;
      mem_d_d       = '0;
      sc_st_d       = 1'b0;
      sc_addr_d     = '0;
      sc_d_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      steady_mode_q <= 1'b0;
      op_q          <= '0;
      regs_q        <= '{default: '0};
      ld_left_q     <= '0;
      ld_addr_q     <= '0;
      st_addr_q     <= '0;
      tag_q         <= '0;
      outst_q       <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_ld_q      <= 1'b0;
      mem_st_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_d_q       <= '0;
      sc_st_q       <= 1'b0;
      sc_addr_q     <= '0;
      sc_d_q        <= '0;
    end else begin
      state_q       <= state_d;
      steady_mode_q <= steady_mode_d;
      op_q          <= op_d;
      regs_q        <= regs_d;
      ld_left_q     <= ld_left_d;
      ld_addr_q     <= ld_addr_d;
      st_addr_q     <= st_addr_d;
      tag_q         <= tag_d;
      outst_q       <= outst_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_ld_q      <= mem_ld_d;
      mem_st_q      <= mem_st_d;
      mem_addr_q    <= mem_addr_d;
      mem_d_q       <= mem_d_d;
      sc_st_q       <= sc_st_d;
      sc_addr_q     <= sc_addr_d;
      sc_d_q        <= sc_d_d;
    end
  end

  // Response FIFO storage; occupancy is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= bus.rsp_mem_q;
  end

  assign op_out                = op_q;
  assign busy_out              = busy_in | (state_q != S_IDLE);
  assign bus.req_mem_ld        = mem_ld_q;
  assign bus.req_mem_st        = mem_st_q;
  assign bus.req_mem_addr      = mem_addr_q;
  assign bus.req_mem_d_or_tag  = mem_d_q;
  assign bus.rsp_mem_stall     = fifo_full_c;
  assign bus.req_scratch_ld    = 1'b0;
  assign bus.req_scratch_st    = sc_st_q;
  assign bus.req_scratch_addr  = sc_addr_q;
  assign bus.req_scratch_d     = sc_d_q;
  assign bus.rsp_scratch_stall = 1'b0;

  assign unused_c = ^{bus.rsp_mem_tag, bus.rsp_scratch_push, bus.rsp_scratch_q};
endmodule

// File: tb/tb_spmv_pe.sv
// Directed bench for spmv_pe: register loads, table copies, STEADY streaming,
// memory stall, busy chaining and both reset flavours, against an in-order memory model.
module tb_spmv_pe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] op_in;
  logic [63:0] op_out;
  logic        busy_in;
  logic        busy_out;

  spmv_pe_if bus_if ();

  spmv_pe #(.ID(0), .OUTSTANDING(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_in    (op_in),
    .op_out   (op_out),
    .busy_in  (busy_in),
    .busy_out (busy_out),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [2:0]  tag;
    logic [63:0] data;
  } rsp_t;

  rsp_t        rq[$];
  int unsigned cyc = 0;
  int unsigned lat = 3;
  int          n_tests = 0;
  int          n_fail = 0;
  int          ld_cnt = 0, ld_bad = 0, sc_cnt = 0, sc_bad = 0, st_cnt = 0, stall_viol = 0;
  int          ld_mark = 0, sc_mark = 0, st_mark = 0;
  logic [47:0] ld_base = '0;
  logic [12:0] sc_base = '0;
  logic [12:0] sc_first = '0;
  logic        rsp_stall_seen = 1'b0;
  logic        stall_at_edge = 1'b0;
  logic [47:0] st_addr_log [16];
  logic [63:0] st_data_log [16];

  function automatic logic [63:0] mem_word(input logic [47:0] a);
    case (a)
      48'h3000: return 64'h3FF0_0000_0000_0000;
      48'h3008: return 64'h4000_0000_0000_0000;
      48'h3010: return 64'h4008_0000_0000_0000;
      default:  return {16'hC0DE, a};
    endcase
  endfunction

  function automatic logic [63:0] mk_op(input logic [5:0] opc, input logic [7:0] pe,
                                        input logic [3:0] idx, input logic [45:0] val);
    return {val, idx, pe, opc};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_op(input logic [63:0] op);
    @(negedge clk);
    op_in = op;
    @(negedge clk);
    op_in = '0;
  endtask

  task automatic ld_reg(input logic [3:0] idx, input logic [45:0] val);
    send_op(mk_op(6'd2, 8'd0, idx, val));
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy_out !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n >= max_cyc), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Stall as seen by the DUT at each rising edge
  initial forever begin
    @(posedge clk);
    stall_at_edge = bus_if.req_mem_stall;
  end

  // In-order memory model with fixed latency plus request scoreboards
  initial begin
    bus_if.rsp_mem_push = 1'b0;
    bus_if.rsp_mem_tag  = '0;
    bus_if.rsp_mem_q    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus_if.rsp_mem_push = 1'b0;
      if (!rst_n) begin
        rq.delete();
      end else begin
        if (bus_if.rsp_mem_stall === 1'b1) rsp_stall_seen = 1'b1;
        if (rq.size() != 0 && rq[0].due <= cyc) begin
          bus_if.rsp_mem_push = 1'b1;
          bus_if.rsp_mem_tag  = rq[0].tag;
          bus_if.rsp_mem_q    = rq[0].data;
          void'(rq.pop_front());
        end
        if (bus_if.req_mem_ld === 1'b1) begin
          if (stall_at_edge) stall_viol++;
          if (bus_if.req_mem_addr !== ld_base + 48'(8 * (ld_cnt - ld_mark)) ||
              bus_if.req_mem_d_or_tag !== 64'((ld_cnt - ld_mark) % 8)) ld_bad++;
          rq.push_back('{cyc + lat, bus_if.req_mem_d_or_tag[2:0], mem_word(bus_if.req_mem_addr)});
          ld_cnt++;
        end
        if (bus_if.req_scratch_st === 1'b1) begin
          if (sc_cnt == sc_mark) sc_first = bus_if.req_scratch_addr;
          if (bus_if.req_scratch_addr !== sc_base + 13'(sc_cnt - sc_mark) ||
              bus_if.req_scratch_d !== mem_word(ld_base + 48'(8 * (sc_cnt - sc_mark)))) sc_bad++;
          sc_cnt++;
        end
        if (bus_if.req_mem_st === 1'b1) begin
          if (st_cnt - st_mark < 16) begin
            st_addr_log[st_cnt - st_mark] = bus_if.req_mem_addr;
            st_data_log[st_cnt - st_mark] = bus_if.req_mem_d_or_tag;
          end
          st_cnt++;
        end
      end
    end
  end

  initial begin
    logic [63:0] op;
    int          snap0, snap1, busy_cyc;
    rst_n = 1'b0;
    op_in = '0;
    busy_in = 1'b0;
    bus_if.req_mem_stall     = 1'b0;
    bus_if.req_scratch_stall = 1'b0;
    bus_if.rsp_scratch_push  = 1'b0;
    bus_if.rsp_scratch_q     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_op_out", op_out, 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_mem_ld", 64'(bus_if.req_mem_ld), 64'd0);
    check("rst_mem_st", 64'(bus_if.req_mem_st), 64'd0);
    check("rst_sc_st", 64'(bus_if.req_scratch_st), 64'd0);
    check("rst_rsp_stall", 64'(bus_if.rsp_mem_stall), 64'd0);

    // LD to this PE and to another PE
    op = mk_op(6'd2, 8'd0, 4'd3, 46'h1234);
    send_op(op);
    check("ld_op_out", op_out, op);
    check("ld_r3", dut.regs_q[3], 64'h1234);
    op = mk_op(6'd2, 8'd1, 4'd3, 46'h9999);
    send_op(op);
    check("ld_other_op_out", op_out, op);
    check("ld_other_r3", dut.regs_q[3], 64'h1234);

    // Large copy with long memory latency
    lat = 2000; ld_base = 48'h1000; sc_base = 13'd0;
    ld_mark = ld_cnt; sc_mark = sc_cnt;
    ld_reg(4'd4, 46'h1000); ld_reg(4'd5, 46'h0); ld_reg(4'd9, 46'd4096);
    send_op(mk_op(6'd3, 8'd0, 4'd0, 46'd0));
    check("copy_busy_rise", 64'(busy_out), 64'd1);
    wait_idle("copy_timeout", 60000);
    check("copy_loads", 64'(ld_cnt - ld_mark), 64'd512);
    check("copy_stores", 64'(sc_cnt - sc_mark), 64'd512);
    check("copy_ld_bad", 64'(ld_bad), 64'd0);
    check("copy_sc_bad", 64'(sc_bad), 64'd0);
    check("copy_rsp_stall", 64'(rsp_stall_seen), 64'd0);
    check("copy_busy_fall", 64'(busy_out), 64'd0);

    // Scratch base offset
    lat = 3; sc_base = 13'd32;
    ld_mark = ld_cnt; sc_mark = sc_cnt;
    ld_reg(4'd5, 46'h100); ld_reg(4'd9, 46'd16);
    send_op(mk_op(6'd4, 8'd0, 4'd0, 46'd0));
    wait_idle("off_timeout", 200);
    check("off_stores", 64'(sc_cnt - sc_mark), 64'd2);
    check("off_first_addr", 64'(sc_first), 64'd32);
    check("off_sc_bad", 64'(sc_bad), 64'd0);

    // Zero-length copy
    ld_mark = ld_cnt; sc_mark = sc_cnt;
    ld_reg(4'd9, 46'd0);
    send_op(mk_op(6'd5, 8'd0, 4'd0, 46'd0));
    busy_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_out === 1'b1) busy_cyc++;
      @(negedge clk);
    end
    check("zero_busy_pulse", 64'(busy_cyc >= 1 && busy_cyc <= 3), 64'd1);
    check("zero_loads", 64'(ld_cnt - ld_mark), 64'd0);
    check("zero_stores", 64'(sc_cnt - sc_mark), 64'd0);

    // STEADY streaming x -> y
    lat = 4; ld_base = 48'h3000;
    ld_mark = ld_cnt; st_mark = st_cnt;
    ld_reg(4'd0, 46'h2000); ld_reg(4'd1, 46'h2018); ld_reg(4'd2, 46'h3000);
    send_op(mk_op(6'd6, 8'd0, 4'd0, 46'd0));
    wait_idle("steady_timeout", 200);
    check("steady_loads", 64'(ld_cnt - ld_mark), 64'd3);
    check("steady_stores", 64'(st_cnt - st_mark), 64'd3);
    check("steady_ld_bad", 64'(ld_bad), 64'd0);
    check("steady_a0", 64'(st_addr_log[0]), 64'h2000);
    check("steady_d0", st_data_log[0], 64'h3FF0_0000_0000_0000);
    check("steady_a1", 64'(st_addr_log[1]), 64'h2008);
    check("steady_d1", st_data_log[1], 64'h4000_0000_0000_0000);
    check("steady_a2", 64'(st_addr_log[2]), 64'h2010);
    check("steady_d2", st_data_log[2], 64'h4008_0000_0000_0000);

    // Memory stall window during a copy
    lat = 5; ld_base = 48'h1000; sc_base = 13'd0;
    ld_mark = ld_cnt; sc_mark = sc_cnt;
    ld_reg(4'd5, 46'h0); ld_reg(4'd9, 46'd512);
    send_op(mk_op(6'd3, 8'd0, 4'd0, 46'd0));
    repeat (4) @(negedge clk);
    bus_if.req_mem_stall = 1'b1;
    @(negedge clk);
    snap0 = ld_cnt;
    repeat (49) @(negedge clk);
    snap1 = ld_cnt;
    bus_if.req_mem_stall = 1'b0;
    check("stall_no_loads", 64'(snap1 - snap0), 64'd0);
    check("stall_loads_pending", 64'(snap0 - ld_mark < 64), 64'd1);
    wait_idle("stall_timeout", 500);
    check("stall_viol", 64'(stall_viol), 64'd0);
    check("stall_loads", 64'(ld_cnt - ld_mark), 64'd64);
    check("stall_stores", 64'(sc_cnt - sc_mark), 64'd64);
    check("stall_sc_bad", 64'(sc_bad), 64'd0);

    // busy chaining while idle
    @(negedge clk);
    busy_in = 1'b1;
    #1 check("busy_in_high", 64'(busy_out), 64'd1);
    @(negedge clk);
    busy_in = 1'b0;
    #1 check("busy_in_low", 64'(busy_out), 64'd0);

    // rst_n mid-copy
    ld_mark = ld_cnt; sc_mark = sc_cnt;
    send_op(mk_op(6'd3, 8'd0, 4'd0, 46'd0));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("arst_mem_ld", 64'(bus_if.req_mem_ld), 64'd0);
    check("arst_mem_st", 64'(bus_if.req_mem_st), 64'd0);
    check("arst_sc_st", 64'(bus_if.req_scratch_st), 64'd0);
    check("arst_busy", 64'(busy_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("arst_r4", dut.regs_q[4], 64'd0);

    // Clean copy after the abort
    ld_mark = ld_cnt; sc_mark = sc_cnt;
    ld_reg(4'd4, 46'h1000); ld_reg(4'd5, 46'h0); ld_reg(4'd9, 46'd32);
    send_op(mk_op(6'd3, 8'd0, 4'd0, 46'd0));
    wait_idle("post_rst_timeout", 200);
    check("post_rst_stores", 64'(sc_cnt - sc_mark), 64'd4);
    check("post_rst_sc_bad", 64'(sc_bad), 64'd0);

    // RST opcode while busy
    ld_mark = ld_cnt; sc_mark = sc_cnt;
    ld_reg(4'd9, 46'd512);
    send_op(mk_op(6'd3, 8'd0, 4'd0, 46'd0));
    repeat (6) @(negedge clk);
    send_op(mk_op(6'd1, 8'd0, 4'd0, 46'd0));
    check("srst_busy", 64'(busy_out), 64'd0);
    check("srst_r9", dut.regs_q[9], 64'd0);
    repeat (12) @(negedge clk);
    check("srst_fifo_empty", 64'(dut.fifo_cnt_q), 64'd0);
    check("srst_busy_stays", 64'(busy_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spmv_pe.md
# spmv_pe

Processing element of the SpMV accelerator chain. It decodes 64-bit broadcast opcodes, holds a 16-entry argument register file, and copies decoder tables from main memory into a local scratchpad. In this revision it also runs a bring-up steady-state pass that streams 64-bit words from the x region into the y region. It sits in a daisy chain: opcodes and busy are forwarded to the next PE, and it has private main-memory and scratchpad ports.

## Interface
- ID, 0: PE index; commands execute only when the opcode PE field equals ID.
- OUTSTANDING, 32: maximum number of in-flight memory loads; also the response FIFO depth.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- op_in / op_out  in/out  64  opcode in; op_out is op_in registered by one cycle and forwarded unchanged.
- busy_in / busy_out  in/out  1  busy_out is busy_in OR the registered internal busy.
- req_mem_ld, req_mem_st  out  1  memory load / store request strobes, at most one per cycle.
- req_mem_addr  out  48  byte address, always 8-byte aligned.
- req_mem_d_or_tag  out  64  store data, or the load tag in [2:0].
- req_mem_stall  in  1  while high, no new memory request may be issued.
- rsp_mem_push, rsp_mem_tag[2:0], rsp_mem_q[63:0]  in  load response; responses return in order with arbitrary latency.
- rsp_mem_stall  out  1  asserted when the response FIFO is full.
- req_scratch_ld, req_scratch_st  out  1  scratchpad load / store strobes.
- req_scratch_addr  out  13  scratchpad word address.
- req_scratch_d  out  64  scratchpad store data.
- req_scratch_stall  in  1  holds scratchpad requests.
- rsp_scratch_push, rsp_scratch_q[63:0]  in  scratchpad load response; unused in this revision.
- rsp_scratch_stall  out  1  tied to 0.

## Operation
- Opcode fields: [5:0] opcode, [13:6] PE, [17:14] register index, [63:18] value (46 bits, zero-extended to 64).
- Opcode values: NOP=0, RST=1, LD=2, LD_DELTA_CODES=3, LD_PREFIX_CODES=4, LD_COMMON_CODES=5, STEADY=6. Undefined opcodes behave as NOP.
- Register use: LD writes the value into r[index]. It is accepted in IDLE only; LD arriving while busy is dropped.
- RST has the same effect as rst_n, applied synchronously: registers, FSM and FIFO are cleared. It is executed even when the PE is busy.
- LD_DELTA_CODES, LD_PREFIX_CODES and LD_COMMON_CODES all run the same copy:
  - words = r9>>3; for k in 0..words-1: load mem[r4+8k], then write the response to scratch address (r5>>3)+k, truncated to 13 bits.
  - r9=0 completes immediately.
  - The three opcodes behave identically in this revision.
- STEADY (bring-up): for k = 0 while r0+8k < r1:
  - load mem[r2+8k];
  - store the returned word to address r0+8k.
  - If r0 >= r1, the pass completes immediately.
- FSM states:
  - IDLE: accepts commands.
  - COPY, STEADY: active.
  - DRAIN: waits until the outstanding count is 0 and the FIFO is empty, then returns to IDLE.
- Load issue: a load is issued when req_mem_stall=0, outstanding < OUTSTANDING, and loads remain. Tags are k mod 8.
- Response path: responses enter the FIFO. The FIFO head is retired as a scratch store (COPY, gated by req_scratch_stall) or a memory store (STEADY).
- Bus priority: in STEADY, a pending store has priority over a new load on the shared memory request port.
- Simultaneous rsp_mem_push and FIFO pop in the same cycle: count is unchanged.

## Timing
- Reset values: all outputs 0; op_out=0; registers 0; FSM in IDLE.
- Commands:
  - op_in is sampled at posedge.
  - Internal busy rises on the edge that captures a copy or STEADY command, so busy_out is high the next cycle.
  - busy_out falls the cycle after DRAIN completes.
- Load latency: the first load is issued at most 2 cycles after the command is captured.
- Store latency: a stored word appears on req_mem_st or req_scratch_st 1–2 cycles after its rsp_mem_push.
- Stall: req_* outputs hold (no new strobe) while the corresponding stall input is high.
- rsp_mem_stall is never asserted in legal use, because outstanding loads are capped at the FIFO depth.
- rst_n low mid-operation aborts immediately. Responses to loads issued before the reset are discarded after the reset.

## Test plan
- Reset, then LD r3=0x1234 to PE 0: register r3 reads 0x1234. The same LD with PE field 1 leaves r3 unchanged. In both cases op_out equals op_in delayed 1 cycle.
- Copy: r4=0x1000, r5=0, r9=4096, then LD_DELTA_CODES with 2000-cycle memory latency:
  - exactly 512 loads and 512 scratch stores at addresses 0..511 with the matching data;
  - rsp_mem_stall stays 0;
  - busy_out drops afterwards.
- Copy with r5=0x100 and r9=16: scratch writes go to addresses 32 and 33. With r9=0, busy_out pulses for ≤3 cycles and no requests are issued.
- STEADY with r0=0x2000, r1=0x2018, r2=0x3000 and mem[0x3000..]=1.0, 2.0, 3.0: stores of 1.0, 2.0, 3.0 to 0x2000, 0x2008 and 0x2010 in order.
- Hold req_mem_stall high for 50 cycles during a copy: no req_mem_ld is issued in that window, and the results are still complete and in order.
- Assert busy_in while idle: busy_out follows it. Assert rst_n low mid-copy: all strobes are 0 and busy_out=0 the next cycle.
